// File: rtl/maincontroller_pkg.sv
// Shared definitions for the multicycle main controller: state encoding, opcodes and datapath select codes.
// MAINCTRL_BNE_EN adds the BNEEX state and the BNE opcode decode.
package maincontroller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MAINCTRL_BNE_EN
    , S_BNEEX = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  // Unsupported opcodes map to FETCH; op_legal tells them apart from a real FETCH target.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LB, OP_SB: decode_next = S_MEMADR;
      OP_RTYPE:     decode_next = S_RTYPEEX;
      OP_BEQ:       decode_next = S_BEQEX;
      OP_ADDI:      decode_next = S_ADDIEX;
      OP_J:         decode_next = S_JEX;
`ifdef MAINCTRL_BNE_EN
      OP_BNE:       decode_next = S_BNEEX;
`endif
      default:      decode_next = S_FETCH;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    op_legal = (decode_next(op) != S_FETCH);
  endfunction

endpackage

// File: rtl/maincontroller_outdec.sv
// Combinational state-to-control decoder; only FETCH looks at memready, only branch states look at zero.
// MAINCTRL_BNE_EN adds the BNEEX decode with inverted branch condition.
module maincontroller_outdec
  import maincontroller_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output ctrl_t      ctrl
);

  logic pcwrite;
  logic branch;
  logic branch_ne;

  always_comb begin
    ctrl      = '0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = memready;
        pcwrite      = memready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.illegal = ~op_legal(op);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        branch       = 1'b1;
      end
`ifdef MAINCTRL_BNE_EN
      S_BNEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        branch_ne    = 1'b1;
      end
`endif
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsrc = PCSRC_JUMP;
        pcwrite    = 1'b1;
      end
      default: ctrl = '0;
    endcase
    ctrl.pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);
  end

endmodule

// File: rtl/maincontroller.sv
// Multicycle Moore main controller: state register, next-state logic and reset gating of all controls.
// MAINCTRL_BNE_EN enables BNE support (BNEEX state).
module maincontroller
  import maincontroller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       pcen,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal
);

  state_t state;
  state_t next;
  logic   run;
  ctrl_t  raw;
  ctrl_t  ctrl;

  // run stays low through reset and until the first clock edge after release,
  // so the first real FETCH cycle begins on that edge and every control reads 0 before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:   if (memready) next = S_DECODE;
      S_DECODE:  next = decode_next(op);
      S_MEMADR:  next = (op == OP_LB) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (memready) next = S_MEMWB;
      S_MEMWR:   if (memready) next = S_FETCH;
      S_RTYPEEX: next = S_RTYPEWB;
      S_ADDIEX:  next = S_ADDIWB;
      default:   next = S_FETCH;
    endcase
  end

  maincontroller_outdec u_outdec (
    .state    (state),
    .op       (op),
    .zero     (zero),
    .memready (memready),
    .ctrl     (raw)
  );

  assign ctrl = run ? raw : '0;

  assign pcen     = ctrl.pcen;
  assign memwrite = ctrl.memwrite;
  assign iord     = ctrl.iord;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_maincontroller.sv
// Directed bench for maincontroller; control vector order is
// {pcen,memwrite,iord,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,illegal}.
module tb_maincontroller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memready;
  logic       pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [14:0] obs;
  int total = 0;
  int bad   = 0;

  localparam logic [14:0] V_ZERO  = 15'b0;
  localparam logic [14:0] V_F1    = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_F0    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [14:0] V_MA    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_MRD   = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_MWR   = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_REX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0};
  localparam logic [14:0] V_RWB   = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_BR0   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [14:0] V_BR1   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [14:0] V_AEX   = V_MA;
  localparam logic [14:0] V_AWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [14:0] V_J     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0};

  maincontroller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .memready (memready),
    .pcen     (pcen),
    .memwrite (memwrite),
    .iord     (iord),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, illegal};

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Apply inputs, check the current cycle's controls, then advance one clock.
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [14:0] exp);
    memready = mr;
    zero     = z;
    #1;
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; op = 6'b000000; zero = 1'b0; memready = 1'b1;
    #12;
    check("reset_hold", obs, V_ZERO);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_release_pre_edge", obs, V_ZERO);
    @(posedge clk);
    #1;

    op = 6'b000000;
    cyc("r_fetch", 1'b1, 1'b0, V_F1);
    cyc("r_decode", 1'b1, 1'b0, V_DEC);
    cyc("r_ex", 1'b1, 1'b0, V_REX);
    cyc("r_wb", 1'b1, 1'b0, V_RWB);

    op = 6'b100000;
    cyc("lb_fetch", 1'b1, 1'b0, V_F1);
    cyc("lb_decode", 1'b1, 1'b0, V_DEC);
    cyc("lb_memadr", 1'b1, 1'b0, V_MA);
    for (int i = 0; i < 3; i++) cyc("lb_memrd_wait", 1'b0, 1'b0, V_MRD);
    cyc("lb_memrd_done", 1'b1, 1'b0, V_MRD);
    cyc("lb_memwb", 1'b1, 1'b0, V_MWB);

    op = 6'b101000;
    cyc("sb_fetch", 1'b1, 1'b0, V_F1);
    cyc("sb_decode", 1'b1, 1'b0, V_DEC);
    cyc("sb_memadr", 1'b1, 1'b0, V_MA);
    cyc("sb_memwr_wait", 1'b0, 1'b0, V_MWR);
    cyc("sb_memwr_done", 1'b1, 1'b0, V_MWR);

    op = 6'b000100;
    cyc("beq_t_fetch", 1'b1, 1'b1, V_F1);
    cyc("beq_t_decode", 1'b1, 1'b1, V_DEC);
    cyc("beq_taken", 1'b1, 1'b1, V_BR1);
    cyc("beq_n_fetch", 1'b1, 1'b0, V_F1);
    cyc("beq_n_decode", 1'b1, 1'b0, V_DEC);
    cyc("beq_not_taken", 1'b1, 1'b0, V_BR0);

    op = 6'b001000;
    cyc("addi_fetch", 1'b1, 1'b0, V_F1);
    cyc("addi_decode_mr0", 1'b0, 1'b0, V_DEC);
    cyc("addi_ex_mr0", 1'b0, 1'b0, V_AEX);
    cyc("addi_wb_mr0", 1'b0, 1'b0, V_AWB);

    op = 6'b000010;
    cyc("j_fetch", 1'b1, 1'b0, V_F1);
    cyc("j_decode", 1'b1, 1'b0, V_DEC);
    cyc("j_ex", 1'b1, 1'b0, V_J);

    op = 6'b111111;
    cyc("ill_fetch", 1'b1, 1'b0, V_F1);
    cyc("ill_decode", 1'b1, 1'b0, V_ILL);
    cyc("ill_back_fetch_wait", 1'b0, 1'b0, V_F0);
    cyc("fetch_hold", 1'b0, 1'b0, V_F0);

    op = 6'b000101;
    cyc("bne_fetch", 1'b1, 1'b0, V_F1);
`ifdef MAINCTRL_BNE_EN
    cyc("bne_decode", 1'b1, 1'b0, V_DEC);
    cyc("bne_taken", 1'b1, 1'b0, V_BR1);
`else
    cyc("bne_illegal", 1'b1, 1'b0, V_ILL);
`endif

    op = 6'b101000;
    cyc("rst_sb_fetch", 1'b1, 1'b0, V_F1);
    cyc("rst_sb_decode", 1'b1, 1'b0, V_DEC);
    cyc("rst_sb_memadr", 1'b1, 1'b0, V_MA);
    memready = 1'b0;
    #1;
    check("rst_sb_memwr", obs, V_MWR);
    reset = 1'b0;
    #1;
    check("rst_async_clear", obs, V_ZERO);
    @(posedge clk);
    #1;
    check("rst_held", obs, V_ZERO);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_after_fetch_wait", 1'b0, 1'b0, V_F0);
    cyc("rst_after_fetch", 1'b1, 1'b0, V_F1);
    cyc("rst_after_decode", 1'b1, 1'b0, V_DEC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maincontroller.md
MAINCONTROLLER -- requirements
Module: maincontroller

Interface
REQ-001 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-002 reset  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-003 op  input  6  opcode field of the instruction register.
REQ-004 zero  input  1  ALU zero flag.
REQ-005 memready  input  1  memory access completes this cycle.
REQ-006 pcen  output  1  PC register write enable.
REQ-007 memwrite  output  1  memory write strobe.
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 irwrite  output  1  instruction register write enable.
REQ-010 regdst  output  1  register write address: 0 = rt, 1 = rd.
REQ-011 memtoreg  output  1  register write data: 0 = ALUOut, 1 = MDR.
REQ-012 regwrite  output  1  register file write enable.
REQ-013 alusrca  output  1  ALU A operand: 0 = PC, 1 = rs.
REQ-014 alusrcb  output  2  ALU B operand: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
REQ-015 pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 aluop  output  2  to ALU control: 00 = add, 01 = subtract, 10 = decode funct.
REQ-017 illegal  output  1  one-cycle flag for an unsupported opcode.

Function
REQ-018 Moore FSM; pcen = pcwrite | (branch & zero); all other outputs decode from state only; outputs not listed for a state are 0.
REQ-019 FETCH: alusrcb=01; pcwrite and irwrite equal memready; holds until memready=1, then DECODE.
REQ-020 DECODE: alusrcb=11, aluop=00. Next state by op: 100000 (LB) or 101000 (SB) -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX. Any other op: illegal=1 for this cycle, then FETCH.
REQ-021 MEMADR: alusrca=1, alusrcb=10, aluop=00; LB -> MEMRD, SB -> MEMWR.
REQ-022 MEMRD: iord=1; holds until memready, then MEMWB. MEMWB: memtoreg=1, regwrite=1 -> FETCH.
REQ-023 MEMWR: iord=1, memwrite=1 held continuously until memready, then FETCH.
REQ-024 RTYPEEX: alusrca=1, aluop=10 -> RTYPEWB. RTYPEWB: regdst=1, regwrite=1 -> FETCH.
REQ-025 BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
REQ-026 ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB. ADDIWB: regwrite=1 -> FETCH.
REQ-027 JEX: pcsrc=10, pcwrite=1 -> FETCH.
REQ-028 With memready=1 every cycle, instruction latency in cycles: LB 5, SB 4, R-type 4, ADDI 4, BEQ 3, J 3.
REQ-029 memready is ignored in all states except FETCH, MEMRD and MEMWR.
REQ-030 regwrite, memwrite and irwrite are never asserted together in the same cycle.

Reset
REQ-031 reset=0 forces the state to FETCH immediately, without waiting for a clock edge, and holds every output at 0.
REQ-032 The first FETCH cycle starts at the first posedge clk after reset rises; reset mid-instruction abandons the instruction and asserts no write strobe.

Configuration
REQ-033 Macro MAINCTRL_BNE_EN defined: op 000101 decodes in DECODE to BNEEX; BNEEX outputs equal BEQEX; pcen = ~zero in BNEEX.
REQ-034 Macro MAINCTRL_BNE_EN undefined: op 000101 is illegal per REQ-020; the BNEEX state does not exist.

Structure
REQ-035 Shared package maincontroller_pkg holds: state encoding, opcode constants, aluop constants (shared with the ALU control stage), alusrcb encodings, pcsrc encodings.
REQ-036 One sub-module, maincontroller_outdec, is a combinational state-to-output decoder; the next-state register and next-state logic stay in maincontroller.

Verification
REQ-037 reset=0 mid-MEMWR with memready=0 -> memwrite=0 immediately; after release, state is FETCH.
REQ-038 op=000000, memready=1 -> aluop sequence 00, 00, 10, 00; regwrite=1 with regdst=1 only in cycle 4; back in FETCH in cycle 5.
REQ-039 op=100000, memready=0 for 3 cycles in MEMRD -> iord held at 1 for 4 cycles; then MEMWB with memtoreg=1 and regwrite=1.
REQ-040 op=000100: zero=1 -> pcen=1 and pcsrc=01 in BEQEX; zero=0 -> pcen=0.
REQ-041 op=111111 -> illegal=1 for exactly one cycle in DECODE; next cycle FETCH; no write strobe asserted.
REQ-042 op=000101: with MAINCTRL_BNE_EN and zero=0 -> pcen=1 in BNEEX; without the macro -> illegal=1.
